// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus master.
// State encoding, bus width and released-bus value.
package mem_bus_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [WORD_SIZE-1:0] HIGH_Z = {WORD_SIZE{1'bz}};

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_CAPT,
    RESP
  } state_t;

endpackage

// File: rtl/mem_bus_master.sv
// Initiator for the 64k x 16 tri-state memory bus.
// One outstanding single-word read or write at a time.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int          WORD_SIZE   = mem_bus_pkg::WORD_SIZE,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_write,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic                 mem_enable,
  output logic                 mem_write_enable,
  output logic [WORD_SIZE-1:0] mem_address,
  inout  wire  [WORD_SIZE-1:0] mem_data
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t               state, state_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [3:0]           cnt, cnt_d;

  logic                 ready_d;
  logic                 rv_d;
  logic                 rw_d;
  logic [WORD_SIZE-1:0] rd_d;
  logic                 en_d;
  logic                 we_d;
  logic [WORD_SIZE-1:0] addr_d;

  // Bus is owned only while the write cycle is on the wires.
  assign mem_data = (state == WRITE) ? wdata_q
                                     : WORD_SIZE'(HIGH_Z);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      wdata_q          <= '0;
      cnt              <= '0;
      req_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      rsp_write        <= 1'b0;
      rsp_rdata        <= '0;
      mem_enable       <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
    end else begin
      state            <= state_d;
      wdata_q          <= wdata_d;
      cnt              <= cnt_d;
      req_ready        <= ready_d;
      rsp_valid        <= rv_d;
      rsp_write        <= rw_d;
      rsp_rdata        <= rd_d;
      mem_enable       <= en_d;
      mem_write_enable <= we_d;
      mem_address      <= addr_d;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d = state;
    wdata_d = wdata_q;
    cnt_d   = cnt;
    ready_d = req_ready;
    rv_d    = rsp_valid;
    rw_d    = rsp_write;
    rd_d    = rsp_rdata;
    en_d    = mem_enable;
    we_d    = mem_write_enable;
    addr_d  = mem_address;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          ready_d = 1'b0;
          en_d    = 1'b1;
          we_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_write ? WRITE : RD_ADDR;
        end
      end
      WRITE: begin
        en_d    = 1'b0;
        we_d    = 1'b0;
        rv_d    = 1'b1;
        rw_d    = 1'b1;
        rd_d    = '0;
        state_d = RESP;
      end
      RD_ADDR: begin
        cnt_d   = WAIT_INIT;
        state_d = RD_CAPT;
      end
      RD_CAPT: begin
        if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else begin
          rd_d    = mem_data;
          en_d    = 1'b0;
          rv_d    = 1'b1;
          rw_d    = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a simple memory model.
// Instance a has no wait states, instance b has two.
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_ready;

  logic        ready_a, rv_a, rw_a, en_a, we_a;
  logic [15:0] rd_a, addr_a;
  wire  [15:0] bus_a;
  logic        ready_b, rv_b, rw_b, en_b, we_b;
  logic [15:0] rd_b, addr_b;
  wire  [15:0] bus_b;

  logic [15:0] mema [0:65535];
  logic [15:0] memb [0:65535];
  logic [15:0] qa, qb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_master #(.WAIT_STATES(0)) u_dut_a (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid & ~sel),
    .req_ready        (ready_a),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rv_a),
    .rsp_ready        (rsp_ready),
    .rsp_write        (rw_a),
    .rsp_rdata        (rd_a),
    .mem_enable       (en_a),
    .mem_write_enable (we_a),
    .mem_address      (addr_a),
    .mem_data         (bus_a)
  );

  mem_bus_master #(.WAIT_STATES(2)) u_dut_b (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid & sel),
    .req_ready        (ready_b),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rv_b),
    .rsp_ready        (rsp_ready),
    .rsp_write        (rw_b),
    .rsp_rdata        (rd_b),
    .mem_enable       (en_b),
    .mem_write_enable (we_b),
    .mem_address      (addr_b),
    .mem_data         (bus_b)
  );

  // Memory a: writes on enable&we, latches read word, drives when enable&!we.
  always @(posedge clk) begin
    if (reset) mema[0] <= 16'hA5C3;
    if (en_a && we_a) mema[addr_a] <= bus_a;
    if (en_a && !we_a) qa <= mema[addr_a];
  end
  assign bus_a = (en_a && !we_a) ? qa : 16'bz;

  // Memory b: same model, file word preloaded at address 0.
  always @(posedge clk) begin
    if (reset) memb[0] <= 16'hA5C3;
    if (en_b && we_b) memb[addr_b] <= bus_b;
    if (en_b && !we_b) qb <= memb[addr_b];
  end
  assign bus_b = (en_b && !we_b) ? qb : 16'bz;

  logic        ready, rv, rw, en, we;
  logic [15:0] rd, addr, bus, q;

  assign ready = sel ? ready_b : ready_a;
  assign rv    = sel ? rv_b    : rv_a;
  assign rw    = sel ? rw_b    : rw_a;
  assign rd    = sel ? rd_b    : rd_a;
  assign en    = sel ? en_b    : en_a;
  assign we    = sel ? we_b    : we_a;
  assign addr  = sel ? addr_b  : addr_a;
  assign bus   = sel ? bus_b   : bus_a;
  assign q     = sel ? qb      : qa;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ready"}, 32'(ready), 32'd1);
    chk({tag, ".rv"},    32'(rv),    32'd0);
    chk({tag, ".rw"},    32'(rw),    32'd0);
    chk({tag, ".rd"},    32'(rd),    32'd0);
    chk({tag, ".en"},    32'(en),    32'd0);
    chk({tag, ".we"},    32'(we),    32'd0);
    chk({tag, ".addr"},  32'(addr),  32'd0);
  endtask

  // While the memory drives, nothing else may disturb the bus.
  always @(negedge clk) begin
    if (!reset && en && !we) begin
      checks++;
      assert (bus === q) else begin
        errors++;
        $error("FAIL bus_read_drive: observed %h expected %h", bus, q);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    sel       = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk_reset("rst_a");
    sel = 1'b1;
    #1;
    chk_reset("rst_b");
    sel = 1'b0;
    reset = 1'b0;

    // write 1234 @ 0010
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0010;
    req_wdata = 16'h1234;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("wr.en",    32'(en),    32'd1);
    chk("wr.we",    32'(we),    32'd1);
    chk("wr.addr",  32'(addr),  32'h0010);
    chk("wr.bus",   32'(bus),   32'h1234);
    chk("wr.ready", 32'(ready), 32'd0);
    chk("wr.rv0",   32'(rv),    32'd0);
    tick();
    chk("wr.rv",    32'(rv),    32'd1);
    chk("wr.rw",    32'(rw),    32'd1);
    chk("wr.rd",    32'(rd),    32'd0);
    chk("wr.en1",   32'(en),    32'd0);
    chk("wr.we1",   32'(we),    32'd0);
    chk("wr.mem",   32'(mema[16'h0010]), 32'h1234);
    tick();
    chk("wr.hs_rv",    32'(rv),    32'd0);
    chk("wr.hs_ready", 32'(ready), 32'd1);

    // read back @ 0010
    req_valid = 1'b1;
    req_write = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("rd.en",   32'(en),   32'd1);
    chk("rd.we",   32'(we),   32'd0);
    chk("rd.addr", 32'(addr), 32'h0010);
    chk("rd.rv0",  32'(rv),   32'd0);
    tick();
    chk("rd.rv1",  32'(rv),   32'd0);
    chk("rd.en1",  32'(en),   32'd1);
    tick();
    chk("rd.rv",   32'(rv),   32'd1);
    chk("rd.rw",   32'(rw),   32'd0);
    chk("rd.rd",   32'(rd),   32'h1234);
    chk("rd.en2",  32'(en),   32'd0);
    tick();
    chk("rd.hs_ready", 32'(ready), 32'd1);

    // back-to-back write BEEF @ FFFF then read, req_valid held
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'hFFFF;
    req_wdata = 16'hBEEF;
    tick();
    req_write = 1'b0;
    chk("b2b.wbus", 32'(bus), 32'hBEEF);
    tick();
    chk("b2b.wrv",    32'(rv),    32'd1);
    chk("b2b.wready", 32'(ready), 32'd0);
    tick();
    chk("b2b.idle_ready", 32'(ready), 32'd1);
    chk("b2b.idle_en",    32'(en),    32'd0);
    tick();
    req_valid = 1'b0;
    chk("b2b.acc_ready", 32'(ready), 32'd0);
    chk("b2b.acc_en",    32'(en),    32'd1);
    chk("b2b.acc_we",    32'(we),    32'd0);
    chk("b2b.acc_addr",  32'(addr),  32'hFFFF);
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("b2b.rrv", 32'(rv), 32'd1);
    chk("b2b.rrd", 32'(rd), 32'hBEEF);

    // stall with rsp_ready low for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.rv",    32'(rv),    32'd1);
      chk("stall.rd",    32'(rd),    32'hBEEF);
      chk("stall.ready", 32'(ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("stall.hs_rv",    32'(rv),    32'd0);
    chk("stall.hs_ready", 32'(ready), 32'd1);
    tick();
    chk("stall.idle", 32'(ready), 32'd1);

    // reset during RD_CAPT
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0010;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rcapt.en", 32'(en), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset("rst_rcapt");

    // reset during WRITE: memory still takes the word
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0020;
    req_wdata = 16'h5A5A;
    tick();
    req_valid = 1'b0;
    chk("rwr.we", 32'(we), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset("rst_write");
    chk("rwr.mem", 32'(mema[16'h0020]), 32'h5A5A);
    tick();
    chk("rwr.no_rv", 32'(rv), 32'd0);

    // instance b: read @ 0000 with two wait states
    sel = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0000;
    tick();
    req_valid = 1'b0;
    chk("ws.en0", 32'(en), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("ws.rv_low", 32'(rv),   32'd0);
      chk("ws.en",     32'(en),   32'd1);
      chk("ws.addr",   32'(addr), 32'h0000);
    end
    tick();
    chk("ws.rv", 32'(rv), 32'd1);
    chk("ws.rd", 32'(rd), 32'hA5C3);
    chk("ws.en_off", 32'(en), 32'd0);
    tick();
    chk("ws.hs_ready", 32'(ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator side of the 64k x 16 tri-state memory bus.
- Accepts single-word read/write requests from the CPU datapath over a valid/ready handshake and drives the memory enable/write-enable/address lines.
- Owns the shared bidirectional data bus only during write cycles. Captures read data and returns it on a response handshake.
- Sits between the control unit and the memory array; one transaction outstanding at a time.

Parameters:
- WORD_SIZE, 16, width of data and address.
- WAIT_STATES, 0, extra cycles held in read-capture before sampling the bus (0..15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  master idle, request accepted when valid & ready.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  WORD_SIZE  target address.
- req_wdata  input  WORD_SIZE  write data.
- rsp_valid  output  1  response present (read data or write ack).
- rsp_ready  input  1  consumer accepts response.
- rsp_write  output  1  response belongs to a write.
- rsp_rdata  output  WORD_SIZE  captured read data (0 for writes).
- mem_enable  output  1  memory enable.
- mem_write_enable  output  1  memory write enable.
- mem_address  output  WORD_SIZE  memory address.
- mem_data  inout  WORD_SIZE  shared data bus; driven only in WRITE state, else 'z.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs registered except the mem_data tri-state, which decodes from the registered state.
- Reset values:
  - state IDLE; req_ready=1; rsp_valid=0; rsp_write=0; rsp_rdata=0.
  - mem_enable=0; mem_write_enable=0; mem_address=0; mem_data='z; wait counter=0.
- States: IDLE, WRITE, RD_ADDR, RD_CAPT, RESP.
- IDLE: req_ready=1, bus released. On accept (edge E0):
  - latch addr/wdata/write;
  - load mem_address;
  - set mem_enable=1, mem_write_enable=req_write;
  - go to WRITE or RD_ADDR.
- WRITE (one cycle):
  - drives mem_data=wdata, enable=1, we=1; memory stores at next edge E1.
  - At E1: enable/we→0, bus→'z, rsp_valid=1, rsp_write=1, rsp_rdata=0, go to RESP.
- RD_ADDR (one cycle):
  - enable=1, we=0; memory latches address at E1.
  - Bus content this cycle is stale and ignored.
  - Go to RD_CAPT, counter=WAIT_STATES.
- RD_CAPT:
  - enable held 1, we 0, same address; memory drives bus.
  - If counter≠0, decrement and stay.
  - When counter==0: at that edge capture mem_data into rsp_rdata, enable→0, rsp_valid=1, rsp_write=0, go to RESP.
- RESP:
  - rsp_valid/rsp_rdata/rsp_write stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid=0, req_ready=1, go to IDLE.
  - A new request is accepted only in IDLE, so there is one idle cycle between transactions.
- Latency, accept edge to rsp_valid high:
  - write: 1 cycle;
  - read: 2+WAIT_STATES cycles.
- Bus contention rule:
  - mem_data is driven only when state==WRITE.
  - The memory drives only when enable & !we, so write and read-drive windows never overlap.
  - Release is combinational on the state change.
- Address/data stable: mem_address never changes while mem_enable=1.
- Reset mid-operation:
  - Next edge forces IDLE; no response is issued for the abandoned transaction.
  - If reset is sampled in WRITE, the memory still samples we=1 at that same edge. The write lands in memory without an ack; the verifier must expect this.
- req_valid deasserting before acceptance is legal. Inputs are ignored outside IDLE.
- Address wrap: 16'hFFFF is a normal address; no arithmetic performed.

Decomposition:
- Shared package mem_bus_pkg: state enum (IDLE, WRITE, RD_ADDR, RD_CAPT, RESP), WORD_SIZE constant, high-impedance constant.
- Single module; no sub-module warranted. Wait-state counter is inline.

Test Plan:
- Write 16'h1234 to 16'h0010, rsp_ready=1:
  - one WRITE cycle with enable=1, we=1, bus=1234;
  - rsp_valid 1 cycle after accept, rsp_write=1;
  - memory[0010]==1234.
- Read 16'h0010 after the above:
  - rsp_valid 2 cycles after accept, rsp_rdata=16'h1234;
  - master never drives bus during read.
- Read preloaded address 16'h0000 with WAIT_STATES=2:
  - rsp_valid exactly 4 cycles after accept;
  - rsp_rdata equals file word;
  - enable held throughout RD_ADDR/RD_CAPT.
- Back-to-back write 16'hBEEF @16'hFFFF then read @16'hFFFF with req_valid held:
  - second accept exactly one cycle after first response handshake;
  - read returns BEEF;
  - no cycle where both sides drive the bus.
- Read with rsp_ready low 3 cycles:
  - rsp_valid/rsp_rdata stable all 3 cycles;
  - req_ready=0 until handshake;
  - IDLE the cycle after.
- Reset asserted during RD_CAPT, and separately during WRITE:
  - next cycle all outputs at reset values, bus 'z, no rsp_valid;
  - the WRITE case shows the memory updated.
